image_mem_responder: RTL

IMAGE_MEM_RESPONDER -- requirements
Module: image_mem_responder

---
 rtl/image_mem_responder.sv | 109 ++++++++++
 1 files changed

// File: rtl/image_mem_responder.sv
// rtl/image_mem_responder.sv - byte image store loaded sequentially, served as 16-bit little-endian reads
module image_mem_responder #(
    parameter int DEPTH  = 30000,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    output logic              loaded,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [15:0]       rd_data,
    output logic              rd_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
    localparam logic [IW-1:0]   LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic {ST_LOAD, ST_SERVE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] wptr;
    logic [7:0]    mem [DEPTH];

    logic          wr_en;
    logic          last_wr;
    logic          in_range;
    logic          hi_ok;
    logic [IW-1:0] lo_idx;
    logic [IW-1:0] hi_idx;

    // clear and rst both veto the write, so a byte arriving with them is dropped
    assign wr_en   = load_ready && load_valid && !clear && !rst;
    assign last_wr = wr_en && (wptr == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_LOAD;
        end else if (last_wr) begin
            state_nxt = ST_SERVE;
        end
    end

    always_comb begin
        load_ready = 1'b0;
        loaded     = 1'b0;
        case (state)
            ST_LOAD:  load_ready = 1'b1;
            ST_SERVE: loaded     = 1'b1;
            default:  load_ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear || last_wr) begin
            wptr <= '0;
        end else if (wr_en) begin
            wptr <= wptr + 1'b1;
        end
    end

    // image contents survive reset and clear
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= load_data;
        end
    end

    // range check on the full address width; indices are forced legal when out of range
    assign in_range = {1'b0, rd_addr} < DEPTH_A;
    assign lo_idx   = in_range ? rd_addr[IW-1:0] : '0;
    assign hi_ok    = lo_idx != LAST_IDX;
    assign hi_idx   = hi_ok ? lo_idx + 1'b1 : lo_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                if (!loaded || !in_range) begin
                    rd_data <= '0;
                    rd_err  <= 1'b1;
                end else begin
                    rd_data <= {(hi_ok ? mem[hi_idx] : 8'h00), mem[lo_idx]};
                    rd_err  <= 1'b0;
                end
            end
        end
    end

endmodule
